// File: rtl/qr_load_ctrl_if.sv
// Handshake bundle between a matrix-load requester and qr_load_ctrl.
// master: drives start/abort/ld_stop; slave: drives load commands and status.
interface qr_load_ctrl_if;
    logic       start;
    logic       abort;
    logic       ld_stop;
    logic       ld_start;
    logic [1:0] ld_col;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] mat_cnt;

    modport master (
        output start, abort, ld_stop,
        input  ld_start, ld_col, busy, done, err, mat_cnt
    );

    modport slave (
        input  start, abort, ld_stop,
        output ld_start, ld_col, busy, done, err, mat_cnt
    );
endinterface

// File: rtl/qr_load_ctrl.sv
// Sequences NCOL column loads of a Q matrix, with load timeout and abort.
// Ports: clk, reset (sync, active-high), bus (slave: start/abort/ld_stop in;
// ld_start/ld_col/busy/done/err/mat_cnt out). All outputs are Moore.
module qr_load_ctrl #(
    parameter int NCOL    = 3,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    qr_load_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    localparam logic [1:0] LAST_COL = 2'(NCOL - 1);
    localparam logic [7:0] T_LAST   = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] col_q, col_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] mat_cnt_q, mat_cnt_d;
    logic [1:0] ld_col_q, ld_col_d;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        timer_d   = timer_q;
        mat_cnt_d = mat_cnt_q;
        ld_col_d  = ld_col_q;

        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            col_d   = 2'd0;
            timer_d = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = ISSUE;
                        col_d   = 2'd0;
                    end
                end
                ISSUE: begin
                    state_d = WAIT;
                    timer_d = 8'd0;
                end
                WAIT: begin
                    // A stop arriving on the final timer cycle still counts.
                    if (bus.ld_stop) begin
                        if (col_q == LAST_COL) begin
                            state_d = DONE;
                        end else begin
                            state_d = ISSUE;
                            col_d   = col_q + 2'd1;
                        end
                    end else if (timer_q == T_LAST) begin
                        state_d = ERR;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                DONE: begin
                    state_d   = IDLE;
                    col_d     = 2'd0;
                    mat_cnt_d = mat_cnt_q + 8'd1;
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // ld_col only changes when a new column is issued.
        if (state_d == ISSUE) begin
            ld_col_d = col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= 2'd0;
            timer_q   <= 8'd0;
            mat_cnt_q <= 8'd0;
            ld_col_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            timer_q   <= timer_d;
            mat_cnt_q <= mat_cnt_d;
            ld_col_q  <= ld_col_d;
        end
    end

    assign bus.ld_start = (state_q == ISSUE);
    assign bus.ld_col   = ld_col_q;
    assign bus.busy     = (state_q == ISSUE) || (state_q == WAIT) ||
                          (state_q == DONE);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = (state_q == ERR);
    assign bus.mat_cnt  = mat_cnt_q;

endmodule

// File: tb/tb_qr_load_ctrl.sv
// Directed testbench for qr_load_ctrl (NCOL=3, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_qr_load_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic man_stop = 1'b0;
    logic resp_stop = 1'b0;

    int delay = 1;
    int drop_col = -1;
    int pend = 0;
    int n_chk = 0;
    int n_fail = 0;

    qr_load_ctrl_if bus ();

    assign bus.start   = start;
    assign bus.abort   = abort;
    assign bus.ld_stop = resp_stop | man_stop;

    qr_load_ctrl #(.NCOL(3), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Load stage model: ld_stop pulses 'delay' cycles after ld_start.
    always @(negedge clk) begin
        resp_stop = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) resp_stop = 1'b1;
        end
        if (bus.ld_start && (int'(bus.ld_col) != drop_col)) pend = delay;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n, output int n_ls,
                              output int n_done, output int n_err);
        n_ls = 0;
        n_done = 0;
        n_err = 0;
        for (int i = 0; i < n; i++) begin
            n_ls += int'(bus.ld_start);
            n_done += int'(bus.done);
            n_err += int'(bus.err);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_chk++;
        if (bus.ld_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ld_start got %b want 0", bus.ld_start);
        end
        n_chk++;
        if (bus.ld_col !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ld_col got %0d want 0", bus.ld_col);
        end
        n_chk++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status got %b want 000",
                     {bus.busy, bus.done, bus.err});
        end
        n_chk++;
        if (bus.mat_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mat_cnt got %0d want 0", bus.mat_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        logic exp_ls, exp_done, exp_busy;
        delay = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp_ls = (c == 1) || (c == 3) || (c == 5);
            exp_done = (c == 7);
            exp_busy = (c <= 7);
            n_chk++;
            if (bus.ld_start !== exp_ls) begin
                n_fail++;
                $display("FAIL nom_ld_start c%0d got %b want %b",
                         c, bus.ld_start, exp_ls);
            end
            if (exp_ls) begin
                n_chk++;
                if (bus.ld_col !== 2'((c - 1) / 2)) begin
                    n_fail++;
                    $display("FAIL nom_ld_col c%0d got %0d want %0d",
                             c, bus.ld_col, (c - 1) / 2);
                end
            end
            n_chk++;
            if (bus.done !== exp_done) begin
                n_fail++;
                $display("FAIL nom_done c%0d got %b want %b",
                         c, bus.done, exp_done);
            end
            n_chk++;
            if (bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL nom_busy c%0d got %b want %b",
                         c, bus.busy, exp_busy);
            end
            tick();
        end
        n_chk++;
        if (bus.mat_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL nom_mat_cnt got %0d want 1", bus.mat_cnt);
        end
    endtask

    task automatic test_slow(input int d, input int cycles,
                             input logic [7:0] exp_cnt);
        int nl, nd, ne;
        delay = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_cycles(cycles, nl, nd, ne);
        n_chk++;
        if (ne != 0 || nd != 1 || nl != 3) begin
            n_fail++;
            $display("FAIL slow_d%0d got err=%0d done=%0d ls=%0d want 0 1 3",
                     d, ne, nd, nl);
        end
        n_chk++;
        if (bus.mat_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL slow_d%0d_mat_cnt got %0d want %0d",
                     d, bus.mat_cnt, exp_cnt);
        end
        delay = 1;
    endtask

    task automatic test_timeout();
        int nl, nd, ne;
        delay = 1;
        drop_col = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 11; c++) tick();
        n_chk++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_last_wait got err=%b busy=%b want 0 1",
                     bus.err, bus.busy);
        end
        tick();
        n_chk++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_err got err=%b busy=%b want 1 0",
                     bus.err, bus.busy);
        end
        start = 1'b1;
        man_stop = 1'b1;
        tick();
        start = 1'b0;
        man_stop = 1'b0;
        run_cycles(3, nl, nd, ne);
        n_chk++;
        if (nl != 0 || nd != 0 || ne != 3) begin
            n_fail++;
            $display("FAIL tmo_hold got ls=%0d done=%0d err=%0d want 0 0 3",
                     nl, nd, ne);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort got err=%b busy=%b want 0 0",
                     bus.err, bus.busy);
        end
        n_chk++;
        if (bus.mat_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL tmo_mat_cnt got %0d want 3", bus.mat_cnt);
        end
        drop_col = -1;
    endtask

    task automatic test_abort();
        int nl, nd, ne;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_chk++;
        if (bus.ld_start !== 1'b1 || bus.ld_col !== 2'd1) begin
            n_fail++;
            $display("FAIL abt_col1 got ls=%b col=%0d want 1 1",
                     bus.ld_start, bus.ld_col);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.ld_start !== 1'b0) begin
            n_fail++;
            $display("FAIL abt_idle got busy=%b ls=%b want 0 0",
                     bus.busy, bus.ld_start);
        end
        run_cycles(5, nl, nd, ne);
        n_chk++;
        if (nd != 0 || bus.mat_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL abt_no_done got done=%0d cnt=%0d want 0 3",
                     nd, bus.mat_cnt);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++;
        if (bus.ld_start !== 1'b1 || bus.ld_col !== 2'd0) begin
            n_fail++;
            $display("FAIL abt_restart got ls=%b col=%0d want 1 0",
                     bus.ld_start, bus.ld_col);
        end
        run_cycles(15, nl, nd, ne);
        n_chk++;
        if (nd != 1 || bus.mat_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL abt_rerun got done=%0d cnt=%0d want 1 4",
                     nd, bus.mat_cnt);
        end
    endtask

    task automatic test_ignored();
        int nl, nd;
        man_stop = 1'b1;
        abort = 1'b1;
        tick();
        man_stop = 1'b0;
        abort = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.ld_start !== 1'b0 ||
            bus.mat_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL ign_idle got busy=%b ls=%b cnt=%0d want 0 0 4",
                     bus.busy, bus.ld_start, bus.mat_cnt);
        end
        nl = 0;
        nd = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            nl += int'(bus.ld_start);
            nd += int'(bus.done);
            start = (c == 2);
            man_stop = (c == 3);
            tick();
        end
        start = 1'b0;
        man_stop = 1'b0;
        n_chk++;
        if (nl != 3 || nd != 1) begin
            n_fail++;
            $display("FAIL ign_count got ls=%0d done=%0d want 3 1", nl, nd);
        end
        n_chk++;
        if (bus.mat_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL ign_mat_cnt got %0d want 5", bus.mat_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int nl, nd, ne;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        n_chk++;
        if (bus.ld_col !== 2'd2 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mrst_pre got col=%0d busy=%b want 2 1",
                     bus.ld_col, bus.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if ({bus.ld_start, bus.ld_col, bus.busy, bus.done, bus.err,
             bus.mat_cnt} !== 14'd0) begin
            n_fail++;
            $display("FAIL mrst_outs got ls=%b col=%0d b=%b d=%b e=%b cnt=%0d want all 0",
                     bus.ld_start, bus.ld_col, bus.busy, bus.done,
                     bus.err, bus.mat_cnt);
        end
        run_cycles(10, nl, nd, ne);
        n_chk++;
        if (nl != 0 || nd != 0) begin
            n_fail++;
            $display("FAIL mrst_quiet got ls=%0d done=%0d want 0 0", nl, nd);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            tick();
            if (bus.done) begin
                n++;
                if (n == 256) start = 1'b0;
                tick();
                if (n == 255) begin
                    n_chk++;
                    if (bus.mat_cnt !== 8'd255) begin
                        n_fail++;
                        $display("FAIL b2b_255 got %0d want 255", bus.mat_cnt);
                    end
                end
                if (n == 256) begin
                    n_chk++;
                    if (bus.mat_cnt !== 8'd0) begin
                        n_fail++;
                        $display("FAIL b2b_wrap got %0d want 0", bus.mat_cnt);
                    end
                    break;
                end
            end
        end
        start = 1'b0;
        n_chk++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 256", n);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_slow(5, 30, 8'd2);
        test_slow(8, 40, 8'd3);
        test_timeout();
        test_abort();
        test_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
